multiport_reg_file: RTL and testbench
=====================================

MULTIPORT_REG_FILE -- requirements
Module: multiport_reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have ports wa_en / wb_en  input  1 each  write enables, ports A and B.
REQ-007 SHALL have ports wa_add / wb_add  input  ADDR_W each  write addresses.
REQ-008 SHALL have ports wa_data / wb_data  input  DATA_W each  write data.
REQ-009 SHALL have ports rl_add / rr_add  input  ADDR_W each  left and right read addresses.
REQ-010 SHALL have ports rl_data / rr_data  output  DATA_W each  registered read data.
REQ-011 SHALL have ports rl_busy / rr_busy  output  1 each  registered scoreboard bit of the read register.
REQ-012 SHALL have ports rsv_en / rsv_add  input  1 / ADDR_W  reserve request; sets the scoreboard bit.
REQ-013 SHALL have port clr_start  input  1  starts a sequential clear of all registers.
REQ-014 SHALL have port clr_busy  output  1  high while a clear is in progress.

Function
REQ-015 Read latency SHALL be 1 cycle: rl_data/rl_busy reflect rl_add sampled at the previous edge; rr likewise.
REQ-016 Port A write SHALL update the register at the edge where wa_en=1; port B likewise.
REQ-017 When both ports write the same address in one cycle, port B data SHALL win.
REQ-018 With ZERO_REG=1, writes to address 0 SHALL be discarded; reads of address 0 SHALL return 0 and busy 0; reserves to address 0 SHALL be ignored.
REQ-019 A write SHALL clear the scoreboard bit of its address; rsv_en SHALL set it.
REQ-020 A reserve and a write to the same address in one cycle SHALL leave the bit set.
REQ-021 FSM states SHALL be IDLE and CLEAR; reset state is IDLE.
REQ-022 IDLE -> CLEAR on clr_start=1; all scoreboard bits SHALL clear at that edge and the counter SHALL load 0.
REQ-023 In CLEAR, one register per cycle SHALL be zeroed, ascending from 0; CLEAR -> IDLE after register DEPTH-1 is zeroed (DEPTH cycles).
REQ-024 clr_busy SHALL be 1 exactly while in CLEAR.
REQ-025 In CLEAR, writes, reserves and clr_start SHALL be ignored; reads SHALL continue and return current contents.

Reset
REQ-026 Asserting rst SHALL immediately zero all registers, scoreboard bits, rl_data, rr_data, rl_busy, rr_busy and clr_busy, and force IDLE, including mid-clear.
REQ-027 After rst deasserts, the first edge SHALL perform normal operation; no clear is implied.

Configuration
REQ-028 Macro MULTIPORT_REG_FILE_BYPASS_EN defined: a read whose address matches an enabled same-cycle write (non-zero address when ZERO_REG=1) SHALL return that write data, port B over A, and busy 0 unless a same-cycle reserve also matches.
REQ-029 Macro undefined: such a read SHALL return the pre-write contents and scoreboard bit.

Structure
REQ-030 A shared package SHALL hold the FSM state typedef (IDLE, CLEAR) and default DATA_W/ADDR_W constants.
REQ-031 One sub-module, reg_file_read_port, SHALL implement one registered read path (select, bypass, busy) and be instantiated twice.

Verification
REQ-032 Write A r3=0x1234_5678, next cycle read rl_add=3 -> rl_data=0x1234_5678 one cycle later.
REQ-033 Same cycle wa r7=0xAAAA_AAAA, wb r7=0x5555_5555 -> r7 reads 0x5555_5555; with BYPASS_EN a same-cycle read of r7 returns 0x5555_5555, without it the old value.
REQ-034 Write r0=0xFFFF_FFFF, reserve r0 (ZERO_REG=1) -> read r0 gives data 0, busy 0.
REQ-035 Reserve r5, read r5 -> rl_busy=1; write r5=0x10 -> next read rl_busy=0, rl_data=0x10; reserve+write r5 same cycle -> busy stays 1.
REQ-036 Fill all registers, pulse clr_start -> clr_busy high 32 cycles, writes ignored, all reads 0 after; assert rst at cycle 10 of clear -> clr_busy=0 and all registers 0 immediately.

Source files
------------

// File: rtl/multiport_reg_file_pkg.sv
// -----------------------------------------------------------------------------
// multiport_reg_file_pkg
// Shared definitions for the multi-port register file:
//   - DEF_DATA_W / DEF_ADDR_W : default register width and address width
//   - rf_state_t              : clear-sequencer state (IDLE, CLEAR)
//   - addr_writable()         : true when an address may be written/reserved
// -----------------------------------------------------------------------------
package multiport_reg_file_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_t;

    // Register 0 is read-only when it is hardwired to zero.
    function automatic logic addr_writable(input logic addr_is_zero,
                                           input int unsigned zero_reg);
        return !((zero_reg != 0) && addr_is_zero);
    endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// -----------------------------------------------------------------------------
// reg_file_read_port
// One registered read path of the register file: selects the addressed
// register and scoreboard bit, optionally forwards same-cycle write data,
// and registers the result (1-cycle latency).
//
// Optional feature: MULTIPORT_REG_FILE_BYPASS_EN -- when defined, a read that
// matches an enabled same-cycle write returns the write data (port B over A)
// with busy = same-cycle reserve match.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_add           read address
//   i_regs, i_sb    current register contents and scoreboard bits
//   i_w*_en/add/data, i_rsv_en/add   qualified write/reserve (bypass only)
//   o_data, o_busy  registered read data and scoreboard bit
// -----------------------------------------------------------------------------
module reg_file_read_port #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        i_add,
    input  logic [DATA_W-1:0]        i_regs [1<<ADDR_W],
    input  logic [(1<<ADDR_W)-1:0]   i_sb,
`ifdef MULTIPORT_REG_FILE_BYPASS_EN
    input  logic                     i_wa_en,
    input  logic [ADDR_W-1:0]        i_wa_add,
    input  logic [DATA_W-1:0]        i_wa_data,
    input  logic                     i_wb_en,
    input  logic [ADDR_W-1:0]        i_wb_add,
    input  logic [DATA_W-1:0]        i_wb_data,
    input  logic                     i_rsv_en,
    input  logic [ADDR_W-1:0]        i_rsv_add,
`endif
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_busy
);

    logic [DATA_W-1:0] w_data;
    logic              w_busy;

    always_comb begin
        w_data = i_regs[i_add];
        w_busy = i_sb[i_add];
`ifdef MULTIPORT_REG_FILE_BYPASS_EN
        // Write enables arrive already qualified (IDLE, writable address).
        if (i_wb_en && (i_wb_add == i_add)) begin
            w_data = i_wb_data;
            w_busy = i_rsv_en && (i_rsv_add == i_add);
        end else if (i_wa_en && (i_wa_add == i_add)) begin
            w_data = i_wa_data;
            w_busy = i_rsv_en && (i_rsv_add == i_add);
        end
`endif
        if ((ZERO_REG != 0) && (i_add == '0)) begin
            w_data = '0;
            w_busy = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_data <= '0;
            o_busy <= 1'b0;
        end else begin
            o_data <= w_data;
            o_busy <= w_busy;
        end
    end

endmodule

// File: rtl/multiport_reg_file.sv
// -----------------------------------------------------------------------------
// multiport_reg_file
// 2-write / 2-read register file with a per-register busy scoreboard and a
// sequential clear engine (one register per cycle, ascending).
//
// Optional feature: MULTIPORT_REG_FILE_BYPASS_EN -- same-cycle write-to-read
// forwarding in the read ports (see reg_file_read_port).
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   wa_en/wa_add/wa_data        write port A
//   wb_en/wb_add/wb_data        write port B (wins over A on same address)
//   rl_add -> rl_data/rl_busy   left read port, 1-cycle latency
//   rr_add -> rr_data/rr_busy   right read port, 1-cycle latency
//   rsv_en/rsv_add              reserve: sets scoreboard bit
//   clr_start / clr_busy        start sequential clear / clear in progress
// -----------------------------------------------------------------------------
module multiport_reg_file
    import multiport_reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_add,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_add,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rl_add,
    input  logic [ADDR_W-1:0] rr_add,
    output logic [DATA_W-1:0] rl_data,
    output logic [DATA_W-1:0] rr_data,
    output logic              rl_busy,
    output logic              rr_busy,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_add,
    input  logic              clr_start,
    output logic              clr_busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    rf_state_t         r_state;
    rf_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_sb;

    logic w_idle;
    logic w_wa_en;
    logic w_wb_en;
    logic w_rsv_en;
    logic w_clr_go;

    // Qualified enables: nothing modifies state during CLEAR, and register 0
    // is untouchable when hardwired.
    assign w_idle   = (r_state == IDLE);
    assign w_wa_en  = wa_en  && w_idle && addr_writable(wa_add  == '0, ZERO_REG);
    assign w_wb_en  = wb_en  && w_idle && addr_writable(wb_add  == '0, ZERO_REG);
    assign w_rsv_en = rsv_en && w_idle && addr_writable(rsv_add == '0, ZERO_REG);
    assign w_clr_go = clr_start && w_idle;

    assign clr_busy = (r_state == CLEAR);

    // ---------------- clear sequencer FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:  if (clr_start)      w_state_nxt = CLEAR;
            CLEAR: if (r_cnt == LAST)  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_clr_go) begin
            r_cnt <= '0;
        end else if (r_state == CLEAR) begin
            r_cnt <= r_cnt + ADDR_W'(1);
        end
    end

    // ---------------- register array ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == CLEAR) begin
            r_regs[r_cnt] <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_wb_en && (wb_add == ADDR_W'(i))) begin
                    r_regs[i] <= wb_data;
                end else if (w_wa_en && (wa_add == ADDR_W'(i))) begin
                    r_regs[i] <= wa_data;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    // Reserve has priority over a same-cycle write clearing the bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb <= '0;
        end else if (w_clr_go) begin
            r_sb <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_rsv_en && (rsv_add == ADDR_W'(i))) begin
                    r_sb[i] <= 1'b1;
                end else if ((w_wa_en && (wa_add == ADDR_W'(i))) ||
                             (w_wb_en && (wb_add == ADDR_W'(i)))) begin
                    r_sb[i] <= 1'b0;
                end
            end
        end
    end

    // ---------------- read ports ----------------
    reg_file_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_read_l (
        .clk       (clk),
        .rst       (rst),
        .i_add     (rl_add),
        .i_regs    (r_regs),
        .i_sb      (r_sb),
`ifdef MULTIPORT_REG_FILE_BYPASS_EN
        .i_wa_en   (w_wa_en),
        .i_wa_add  (wa_add),
        .i_wa_data (wa_data),
        .i_wb_en   (w_wb_en),
        .i_wb_add  (wb_add),
        .i_wb_data (wb_data),
        .i_rsv_en  (w_rsv_en),
        .i_rsv_add (rsv_add),
`endif
        .o_data    (rl_data),
        .o_busy    (rl_busy)
    );

    reg_file_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_read_r (
        .clk       (clk),
        .rst       (rst),
        .i_add     (rr_add),
        .i_regs    (r_regs),
        .i_sb      (r_sb),
`ifdef MULTIPORT_REG_FILE_BYPASS_EN
        .i_wa_en   (w_wa_en),
        .i_wa_add  (wa_add),
        .i_wa_data (wa_data),
        .i_wb_en   (w_wb_en),
        .i_wb_add  (wb_add),
        .i_wb_data (wb_data),
        .i_rsv_en  (w_rsv_en),
        .i_rsv_add (rsv_add),
`endif
        .o_data    (rr_data),
        .o_busy    (rr_busy)
    );

endmodule

// File: tb/tb_multiport_reg_file.sv
// -----------------------------------------------------------------------------
// tb_multiport_reg_file
// Self-checking bench for multiport_reg_file (DATA_W=32, ADDR_W=5, ZERO_REG=1).
// Reference model: plain arrays for contents/scoreboard and a queue of
// addresses still to be cleared. Honours MULTIPORT_REG_FILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_multiport_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        wa_en, wb_en, rsv_en, clr_start;
    logic [4:0]  wa_add, wb_add, rl_add, rr_add, rsv_add;
    logic [31:0] wa_data, wb_data;
    logic [31:0] rl_data, rr_data;
    logic        rl_busy, rr_busy, clr_busy;

    always #5 clk = ~clk;

    multiport_reg_file #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .ZERO_REG (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wa_en     (wa_en),
        .wa_add    (wa_add),
        .wa_data   (wa_data),
        .wb_en     (wb_en),
        .wb_add    (wb_add),
        .wb_data   (wb_data),
        .rl_add    (rl_add),
        .rr_add    (rr_add),
        .rl_data   (rl_data),
        .rr_data   (rr_data),
        .rl_busy   (rl_busy),
        .rr_busy   (rr_busy),
        .rsv_en    (rsv_en),
        .rsv_add   (rsv_add),
        .clr_start (clr_start),
        .clr_busy  (clr_busy)
    );

    int checks = 0;
    int passes = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_mem [32];
    bit          m_sb  [32];
    int          m_clr_q [$];   // addresses still to be zeroed by a clear

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = '0;
            m_sb[i]  = 1'b0;
        end
        m_clr_q.delete();
    endfunction

    function automatic void exp_read(input logic [4:0] a, output logic [31:0] d, output logic b);
        d = m_mem[a];
        b = m_sb[a];
`ifdef MULTIPORT_REG_FILE_BYPASS_EN
        if (m_clr_q.size() == 0) begin
            if (wb_en && wb_add == a) begin
                d = wb_data;
                b = rsv_en && (rsv_add == a);
            end else if (wa_en && wa_add == a) begin
                d = wa_data;
                b = rsv_en && (rsv_add == a);
            end
        end
`endif
        if (a == 5'd0) begin
            d = '0;
            b = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        if (m_clr_q.size() != 0) begin
            m_mem[m_clr_q.pop_front()] = '0;
        end else begin
            // A first, then B: B overwrites A on the same address.
            if (wa_en && wa_add != 0) m_mem[wa_add] = wa_data;
            if (wb_en && wb_add != 0) m_mem[wb_add] = wb_data;
            if (wa_en) m_sb[wa_add] = 1'b0;
            if (wb_en) m_sb[wb_add] = 1'b0;
            if (rsv_en && rsv_add != 0) m_sb[rsv_add] = 1'b1;
            if (clr_start) begin
                for (int i = 0; i < 32; i++) begin
                    m_sb[i] = 1'b0;
                    m_clr_q.push_back(i);
                end
            end
        end
    endfunction

    // One clock: predict, advance model, clock DUT, compare.
    task automatic step();
        logic [31:0] el, er;
        logic        elb, erb;
        exp_read(rl_add, el, elb);
        exp_read(rr_add, er, erb);
        model_edge();
        @(posedge clk);
        #1;
        chk("rl_data",  rl_data,          el);
        chk("rr_data",  rr_data,          er);
        chk("rl_busy",  {31'b0, rl_busy}, {31'b0, elb});
        chk("rr_busy",  {31'b0, rr_busy}, {31'b0, erb});
        chk("clr_busy", {31'b0, clr_busy}, {31'b0, m_clr_q.size() != 0});
    endtask

    task automatic quiet();
        wa_en = 0; wb_en = 0; rsv_en = 0; clr_start = 0;
    endtask

    task automatic fill_all();
        for (int i = 0; i < 32; i++) begin
            wa_en = 1; wa_add = 5'(i); wa_data = $urandom | 32'h1;
            rl_add = 5'($urandom); rr_add = 5'($urandom);
            step();
        end
        quiet();
    endtask

    int busy_cnt;

    initial begin
        rst = 1'b1;
        quiet();
        wa_add = 0; wb_add = 0; rsv_add = 0; rl_add = 0; rr_add = 0;
        wa_data = 0; wb_data = 0;
        model_reset();

        // Reset state
        #12;
        chk("rst_rl_data",  rl_data,           32'h0);
        chk("rst_rr_data",  rr_data,           32'h0);
        chk("rst_rl_busy",  {31'b0, rl_busy},  32'h0);
        chk("rst_rr_busy",  {31'b0, rr_busy},  32'h0);
        chk("rst_clr_busy", {31'b0, clr_busy}, 32'h0);
        rst = 1'b0;

        // Write A r3, then read it
        wa_en = 1; wa_add = 3; wa_data = 32'h1234_5678;
        step();
        quiet(); rl_add = 3;
        step();
        chk("r3_read", rl_data, 32'h1234_5678);

        // Dual write r7, B wins; same-cycle read of r7
        wa_en = 1; wa_add = 7; wa_data = 32'hAAAA_AAAA;
        wb_en = 1; wb_add = 7; wb_data = 32'h5555_5555;
        rl_add = 7; rr_add = 7;
        step();
`ifdef MULTIPORT_REG_FILE_BYPASS_EN
        chk("r7_bypass", rl_data, 32'h5555_5555);
`else
        chk("r7_old", rl_data, 32'h0);
`endif
        quiet();
        step();
        chk("r7_b_wins", rr_data, 32'h5555_5555);

        // Register 0 hardwired
        wa_en = 1; wa_add = 0; wa_data = 32'hFFFF_FFFF;
        step();
        quiet(); rsv_en = 1; rsv_add = 0;
        step();
        quiet(); rl_add = 0;
        step();
        chk("r0_data", rl_data, 32'h0);
        chk("r0_busy", {31'b0, rl_busy}, 32'h0);

        // Scoreboard on r5
        rsv_en = 1; rsv_add = 5;
        step();
        quiet(); rl_add = 5;
        step();
        chk("r5_rsv_busy", {31'b0, rl_busy}, 32'h1);
        wa_en = 1; wa_add = 5; wa_data = 32'h10;
        step();
        quiet();
        step();
        chk("r5_wr_busy", {31'b0, rl_busy}, 32'h0);
        chk("r5_wr_data", rl_data, 32'h10);
        wa_en = 1; wa_add = 5; wa_data = 32'h20; rsv_en = 1; rsv_add = 5;
        step();
        quiet();
        step();
        chk("r5_rsv_wr_busy", {31'b0, rl_busy}, 32'h1);

        // Randomised traffic, occasional clears
        for (int n = 0; n < 400; n++) begin
            wa_en = 1'($urandom); wa_add = 5'($urandom); wa_data = $urandom;
            wb_en = 1'($urandom); wb_add = 5'($urandom); wb_data = $urandom;
            rsv_en = ($urandom_range(0, 3) == 0); rsv_add = 5'($urandom);
            clr_start = ($urandom_range(0, 63) == 0);
            rl_add = 5'($urandom); rr_add = 5'($urandom);
            if ($urandom_range(0, 3) == 0) rr_add = wb_add;
            step();
        end
        quiet();
        for (int n = 0; n < 34; n++) step();  // drain any clear in flight

        // Full clear with writes/reserves/clr_start ignored
        fill_all();
        clr_start = 1;
        step();
        busy_cnt = (clr_busy === 1'b1) ? 1 : 0;
        for (int n = 0; n < 40; n++) begin
            wa_en = 1; wa_add = 5'($urandom); wa_data = $urandom;
            wb_en = 1; wb_add = 5'($urandom); wb_data = $urandom;
            rsv_en = 1; rsv_add = 5'($urandom); clr_start = 1'($urandom);
            rl_add = 5'($urandom); rr_add = 5'($urandom);
            if (n >= 30) quiet();
            step();
            if (clr_busy === 1'b1) busy_cnt++;
        end
        chk("clr_cycles", 32'(busy_cnt), 32'd32);
        quiet();
        for (int i = 0; i < 32; i++) begin
            rl_add = 5'(i); rr_add = 5'(31 - i);
            step();
            chk("post_clr_zero", rl_data | rr_data, 32'h0);
        end

        // Reset in the middle of a clear
        fill_all();
        clr_start = 1;
        step();
        quiet();
        for (int n = 0; n < 9; n++) step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("midclr_clr_busy", {31'b0, clr_busy}, 32'h0);
        chk("midclr_rl_data",  rl_data,           32'h0);
        chk("midclr_rr_data",  rr_data,           32'h0);
        chk("midclr_busy",     {30'b0, rl_busy, rr_busy}, 32'h0);
        #1 rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rl_add = 5'(i); rr_add = 5'(31 - i);
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
